// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-block Wishbone arbiter.
//   t_arb_state : arbiter FSM states
//   C_M0, C_M1  : bit positions of the two masters in grant/request vectors
//   rr_pick2    : two-way round-robin pick, returns a one-hot grant
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } t_arb_state;

    localparam int C_M0 = 0;
    localparam int C_M1 = 1;

    // req[C_Mx] is master x's request; last = 1 means m1 owned the previous
    // transaction. On a tie the master that did not go last wins.
    function automatic logic [1:0] rr_pick2(input logic [1:0] req, input logic last);
        logic [1:0] grant;
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/uart_wb_arbiter.sv
// Two-master arbiter in front of the single Wishbone slave port of the UART
// register block (addr 0 = TX data, addr 1 = RX data).
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_mX_we/stb/addr/data     : master X request (X = 0 host, 1 loopback engine)
//   o_mX_data/ack/err         : read data, 1-cycle completion / timeout pulses
//   o_s_we/stb/addr/data      : slave request, stb is a single-cycle pulse
//   i_s_data, i_s_ack         : slave response
//   o_grant                   : one-hot owner, 0 while idle
//   o_busy                    : high whenever a transaction is in flight
// One transaction at a time, round-robin per transaction, no preemption.
// Every output is a register; the next state is decided combinationally.
module uart_wb_arbiter
    import uart_pkg::*;
#(
    parameter int G_WORD_WIDTH = 8,
    parameter int G_TIMEOUT    = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_m0_we,
    input  logic                    i_m0_stb,
    input  logic                    i_m0_addr,
    input  logic [G_WORD_WIDTH-1:0] i_m0_data,
    output logic [G_WORD_WIDTH-1:0] o_m0_data,
    output logic                    o_m0_ack,
    output logic                    o_m0_err,
    input  logic                    i_m1_we,
    input  logic                    i_m1_stb,
    input  logic                    i_m1_addr,
    input  logic [G_WORD_WIDTH-1:0] i_m1_data,
    output logic [G_WORD_WIDTH-1:0] o_m1_data,
    output logic                    o_m1_ack,
    output logic                    o_m1_err,
    output logic                    o_s_we,
    output logic                    o_s_stb,
    output logic                    o_s_addr,
    output logic [G_WORD_WIDTH-1:0] o_s_data,
    input  logic [G_WORD_WIDTH-1:0] i_s_data,
    input  logic                    i_s_ack,
    output logic [1:0]              o_grant,
    output logic                    o_busy
);

    localparam int CW = $clog2(G_TIMEOUT + 1);

    t_arb_state    state_reg;
    t_arb_state    state_next;
    logic [CW-1:0] cnt_reg;
    logic          last_reg;
    logic [1:0]    pick;
    logic          timeout_hit;

    always_comb begin
        pick        = rr_pick2({i_m1_stb, i_m0_stb}, last_reg);
        timeout_hit = (cnt_reg == CW'(G_TIMEOUT - 1));
        state_next  = state_reg;
        case (state_reg)
            ST_IDLE:  if (pick != 2'b00) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            // An ack on the same edge the counter expires still completes normally.
            ST_WAIT:  if (i_s_ack || timeout_hit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b1;   // m0 wins the first tie
            o_m0_data <= '0;
            o_m0_ack  <= 1'b0;
            o_m0_err  <= 1'b0;
            o_m1_data <= '0;
            o_m1_ack  <= 1'b0;
            o_m1_err  <= 1'b0;
            o_s_we    <= 1'b0;
            o_s_stb   <= 1'b0;
            o_s_addr  <= 1'b0;
            o_s_data  <= '0;
            o_grant   <= 2'b00;
            o_busy    <= 1'b0;
        end else begin
            state_reg <= state_next;
            o_busy    <= (state_next != ST_IDLE);
            // Pulses default low; they are raised for exactly one cycle below.
            o_s_stb   <= 1'b0;
            o_m0_ack  <= 1'b0;
            o_m0_err  <= 1'b0;
            o_m1_ack  <= 1'b0;
            o_m1_err  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick != 2'b00) begin
                        o_grant  <= pick;
                        last_reg <= pick[C_M1];
                        o_s_stb  <= 1'b1;
                        // Owner request is captured once here and held to the end.
                        if (pick[C_M1]) begin
                            o_s_we   <= i_m1_we;
                            o_s_addr <= i_m1_addr;
                            o_s_data <= i_m1_data;
                        end else begin
                            o_s_we   <= i_m0_we;
                            o_s_addr <= i_m0_addr;
                            o_s_data <= i_m0_data;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_reg <= '0;
                end
                ST_WAIT: begin
                    if (i_s_ack) begin
                        if (o_grant[C_M1]) begin
                            o_m1_data <= i_s_data;
                            o_m1_ack  <= 1'b1;
                        end else begin
                            o_m0_data <= i_s_data;
                            o_m0_ack  <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        if (o_grant[C_M1]) begin
                            o_m1_err <= 1'b1;
                        end else begin
                            o_m0_err <= 1'b1;
                        end
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    o_grant <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Self-checking bench for uart_wb_arbiter: a table of single-master
// transactions followed by hand-written reset, tie and no-preemption sequences.
module tb_uart_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_we, m0_stb, m0_addr;
    logic [7:0] m0_wd, m0_rd;
    logic       m0_ack, m0_err;
    logic       m1_we, m1_stb, m1_addr;
    logic [7:0] m1_wd, m1_rd;
    logic       m1_ack, m1_err;
    logic       s_we, s_stb, s_addr;
    logic [7:0] s_wd, s_rd;
    logic       s_ack;
    logic [1:0] grant;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_wb_arbiter dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_m0_we   (m0_we),
        .i_m0_stb  (m0_stb),
        .i_m0_addr (m0_addr),
        .i_m0_data (m0_wd),
        .o_m0_data (m0_rd),
        .o_m0_ack  (m0_ack),
        .o_m0_err  (m0_err),
        .i_m1_we   (m1_we),
        .i_m1_stb  (m1_stb),
        .i_m1_addr (m1_addr),
        .i_m1_data (m1_wd),
        .o_m1_data (m1_rd),
        .o_m1_ack  (m1_ack),
        .o_m1_err  (m1_err),
        .o_s_we    (s_we),
        .o_s_stb   (s_stb),
        .o_s_addr  (s_addr),
        .o_s_data  (s_wd),
        .i_s_data  (s_rd),
        .i_s_ack   (s_ack),
        .o_grant   (grant),
        .o_busy    (busy)
    );

    typedef struct {
        int         m;         // 0 or 1
        logic       we;
        logic       addr;
        logic [7:0] wd;
        logic [7:0] rd;        // slave return data
        int         dly;       // cycles after stb that the slave acks, -1 never
        int         exp_done;  // edges after ISSUE edge when ack/err is visible
        logic       exp_err;
        logic [7:0] exp_d0;
        logic [7:0] exp_d1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic stb, input logic we,
                           input logic addr, input logic [7:0] d);
        if (m == 0) begin
            m0_stb = stb; m0_we = we; m0_addr = addr; m0_wd = d;
        end else begin
            m1_stb = stb; m1_we = we; m1_addr = addr; m1_wd = d;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_slave"}, {s_stb, s_we, s_addr, s_wd}, 0);
        chk({tag, "_ackerr"}, {m0_ack, m0_err, m1_ack, m1_err}, 0);
        chk({tag, "_rdata"}, {m0_rd, m1_rd}, 0);
        chk({tag, "_grant_busy"}, {grant, busy}, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  c;
        bit  done;
        drive_m(v.m, 1'b1, v.we, v.addr, v.wd);
        step();
        chk("issue_stb", s_stb, 1);
        chk("issue_we", s_we, v.we);
        chk("issue_addr", s_addr, v.addr);
        chk("issue_data", s_wd, v.wd);
        chk("issue_grant", grant, (v.m == 1) ? 2'b10 : 2'b01);
        chk("issue_busy", busy, 1);
        s_rd  = v.rd;
        s_ack = (v.dly == 0);
        c     = 0;
        done  = 1'b0;
        while (!done && c < 40) begin
            c++;
            step();
            chk("stb_single", s_stb, 0);
            if (m0_ack | m0_err | m1_ack | m1_err) done = 1'b1;
            else s_ack = (v.dly == c);
        end
        chk("done_cycle", c, v.exp_done);
        chk("owner_ack", (v.m == 1) ? m1_ack : m0_ack, !v.exp_err);
        chk("owner_err", (v.m == 1) ? m1_err : m0_err, v.exp_err);
        chk("other_quiet", (v.m == 1) ? {m0_ack, m0_err} : {m1_ack, m1_err}, 0);
        $display("txn %0d: m%0d we=%0b addr=%0b wd=%02h done@%0d ack=%0b err=%0b d0=%02h d1=%02h",
                 idx, v.m, v.we, v.addr, v.wd, c, m0_ack | m1_ack, m0_err | m1_err, m0_rd, m1_rd);
        drive_m(v.m, 1'b0, v.we, v.addr, v.wd);
        // After a timeout the slave answers late; that ack must be ignored.
        s_ack = v.exp_err;
        s_rd  = v.exp_err ? 8'hEE : v.rd;
        step();
        chk("end_grant_busy", {grant, busy}, 0);
        chk("end_pulses", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        chk("end_d0", m0_rd, v.exp_d0);
        chk("end_d1", m1_rd, v.exp_d1);
        if (v.exp_err) begin
            step();
            chk("late_ack_busy", busy, 0);
            chk("late_ack_pulses", {m0_ack, m0_err, m1_ack, m1_err}, 0);
            chk("late_ack_data", {m0_rd, m1_rd}, {v.exp_d0, v.exp_d1});
        end
        s_ack = 1'b0;
    endtask

    initial begin
        int  cyc;
        int  last_stb;
        int  own;
        bit  found;

        vecs[0] = '{0, 1'b1, 1'b0, 8'hA5, 8'h11,  1,  2, 1'b0, 8'h11, 8'h00};
        vecs[1] = '{1, 1'b0, 1'b1, 8'h00, 8'h3C,  1,  2, 1'b0, 8'h11, 8'h3C};
        vecs[2] = '{0, 1'b0, 1'b1, 8'h00, 8'h5A,  3,  4, 1'b0, 8'h5A, 8'h3C};
        vecs[3] = '{0, 1'b1, 1'b0, 8'h77, 8'hEE, -1, 16, 1'b1, 8'h5A, 8'h3C};
        vecs[4] = '{1, 1'b1, 1'b1, 8'hC3, 8'h99,  0, 16, 1'b1, 8'h5A, 8'h3C};
        vecs[5] = '{1, 1'b0, 1'b0, 8'h00, 8'h96, 14, 15, 1'b0, 8'h5A, 8'h96};
        vecs[6] = '{0, 1'b0, 1'b0, 8'h00, 8'h42, 15, 16, 1'b0, 8'h42, 8'h96};

        rst_n = 1'b0;
        m0_stb = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
        m1_stb = 0; m1_we = 0; m1_addr = 0; m1_wd = 0;
        s_ack = 0; s_rd = 0;
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", {grant, busy}, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset asserted during WAIT: outputs clear at once, nothing completes.
        drive_m(0, 1'b1, 1'b1, 1'b1, 8'hFF);
        step();
        step();
        chk("pre_abort_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        step();
        drive_m(0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_quiet", {m0_ack, m0_err, m1_ack, m1_err, busy}, 0);
        end
        $display("txn abort: reset in WAIT, no completion issued");

        // Tie: both masters keep requesting; expect m0, m1, m0 at 4-cycle spacing.
        drive_m(0, 1'b1, 1'b1, 1'b0, 8'h10);
        drive_m(1, 1'b1, 1'b0, 1'b1, 8'h20);
        s_rd = 8'h55;
        cyc = 0;
        last_stb = 0;
        for (int r = 0; r < 3; r++) begin
            own   = r % 2;
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                step();
                cyc++;
                if (s_stb) found = 1'b1;
            end
            chk("tie_stb_seen", found, 1);
            chk("tie_grant", grant, (own == 1) ? 2'b10 : 2'b01);
            chk("tie_sdata", s_wd, (own == 1) ? 8'h20 : 8'h10);
            if (r > 0) chk("tie_spacing", cyc - last_stb, 4);
            last_stb = cyc;
            step();
            cyc++;
            s_ack = 1'b1;
            step();
            cyc++;
            s_ack = 1'b0;
            chk("tie_ack_owner", (own == 1) ? m1_ack : m0_ack, 1);
            chk("tie_ack_other", (own == 1) ? m0_ack : m1_ack, 0);
            $display("txn tie %0d: grant=%02b sdata=%02h", r, grant, s_wd);
            if (own == 1) m1_stb = 1'b0; else m0_stb = 1'b0;
            if (r == 2) begin
                m0_stb = 1'b0;
                m1_stb = 1'b0;
            end
            step();
            cyc++;
            if (r < 2) begin
                if (own == 1) m1_stb = 1'b1; else m0_stb = 1'b1;
            end
        end

        // m1 waits behind m0; m0's mid-transaction address change has no effect.
        drive_m(0, 1'b1, 1'b0, 1'b0, 8'h00);
        s_rd = 8'h6B;
        step();
        chk("np_grant_m0", grant, 2'b01);
        chk("np_addr_first", s_addr, 0);
        drive_m(1, 1'b1, 1'b1, 1'b1, 8'hD2);
        step();
        drive_m(0, 1'b1, 1'b1, 1'b1, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("np_held", {s_stb, s_we, s_addr, s_wd, grant}, {1'b0, 1'b0, 1'b0, 8'h00, 2'b01});
        end
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        chk("np_m0_ack", {m0_ack, m1_ack, grant}, {1'b1, 1'b0, 2'b01});
        chk("np_m0_data", m0_rd, 8'h6B);
        drive_m(0, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        chk("np_done_idle", {s_stb, grant}, 0);
        step();
        chk("np_m1_issue", {s_stb, s_we, s_addr, s_wd, grant}, {1'b1, 1'b1, 1'b1, 8'hD2, 2'b10});
        s_rd = 8'h4E;
        step();
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        chk("np_m1_ack", {m1_ack, m0_ack}, 2'b10);
        chk("np_m1_data", m1_rd, 8'h4E);
        chk("np_m0_keep", m0_rd, 8'h6B);
        $display("txn nopreempt: m0 addr=0 then m1 grant=%02b d1=%02h", grant, m1_rd);
        drive_m(1, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
